// File: rtl/accum_arbiter_pkg.sv
// Shared constants and types for the accumulator arbiter slice.
// Also records the limits of the floating-point accumulator it feeds.
package accum_arbiter_pkg;

  localparam int DEF_FRAC_WIDTH  = 24;
  localparam int DEF_EXP_WIDTH   = 8;
  localparam int ACC_ADD_LATENCY = 4;
  // Sum IDs the accumulator can track in flight; tag FIFO depth must not exceed it.
  localparam int ACC_MAX_IDS     = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arbState_t;

  function automatic int reqWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_arbiter_fifo.sv
// Synchronous FIFO holding the requester tags of outstanding sums.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             pushIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             popIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             fullOut,
  output logic             emptyOut,
  output logic [CNT_W-1:0] countOut
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doPush, doPop;

  assign fullOut  = (countOut == CNT_W'(DEPTH));
  assign emptyOut = (countOut == '0);
  assign doPush   = pushIn && !fullOut;
  assign doPop    = popIn && !emptyOut;
  assign dataOut  = mem[rdPtr];

  always_ff @(posedge clkIn) begin
    if (doPush) mem[wrPtr] <= dataIn;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countOut <= '0;
    end else begin
      if (doPush) wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      if (doPop)  rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   countOut <= countOut + 1'b1;
        2'b01:   countOut <= countOut - 1'b1;
        default: countOut <= countOut;
      endcase
    end
  end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin packet arbiter sharing one FP accumulator between NUM_REQ requesters,
// with an in-order tag FIFO that steers each returned sum to its owner.
module accum_arbiter
  import accum_arbiter_pkg::*;
#(
  parameter int FRAC_WIDTH      = DEF_FRAC_WIDTH,
  parameter int EXP_WIDTH       = DEF_EXP_WIDTH,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int DATA_WIDTH     = FRAC_WIDTH + EXP_WIDTH,
  localparam int REQ_W          = reqWidth(NUM_REQ)
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  input  logic [NUM_REQ-1:0]            reqLastIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [DATA_WIDTH-1:0]         accDataOut,
  output logic                          accValidOut,
  output logic                          accLastOut,
  input  logic [DATA_WIDTH-1:0]         accDataIn,
  input  logic                          accValidIn,
  output logic [DATA_WIDTH-1:0]         resDataOut,
  output logic [NUM_REQ-1:0]            resValidOut,
  output logic                          busyOut,
  output logic                          errOut
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arbState_t             state, nextState;
  logic [REQ_W-1:0]      grant, rrPtr, winner, cand, headTag;
  logic                  found, pushTag, popTag, beatAccept;
  logic                  grantValid, grantLast;
  logic [DATA_WIDTH-1:0] grantData;
  logic                  fifoFull, fifoEmpty;
  logic [CNT_W-1:0]      occupancy;

  // First valid requester at or after rrPtr, wrapping at NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = REQ_W'((32'(rrPtr) + i) % NUM_REQ);
      if (!found && reqValidIn[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grantData = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant == REQ_W'(r)) grantData = reqDataIn[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grantValid = reqValidIn[grant];
  assign grantLast  = reqLastIn[grant];

  always_comb begin
    nextState   = state;
    pushTag     = 1'b0;
    beatAccept  = 1'b0;
    reqReadyOut = '0;
    case (state)
      IDLE: begin
        if (found && !fifoFull) begin
          pushTag   = 1'b1;
          nextState = STREAM;
        end
      end
      STREAM: begin
        reqReadyOut = NUM_REQ'(1) << grant;
        beatAccept  = grantValid;
        if (grantValid && grantLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state <= IDLE;
      grant <= '0;
      rrPtr <= '0;
    end else begin
      state <= nextState;
      if (pushTag) grant <= winner;
      if (beatAccept && grantLast)
        rrPtr <= (grant == REQ_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      accDataOut  <= '0;
      accValidOut <= 1'b0;
      accLastOut  <= 1'b0;
    end else begin
      if (beatAccept) accDataOut <= grantData;
      accValidOut <= beatAccept;
      accLastOut  <= beatAccept && grantLast;
    end
  end

  // A result with no outstanding tag is flagged and otherwise dropped.
  assign popTag = accValidIn && !fifoEmpty;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      resDataOut  <= '0;
      resValidOut <= '0;
      errOut      <= 1'b0;
    end else begin
      resValidOut <= popTag ? (NUM_REQ'(1) << headTag) : '0;
      if (popTag) resDataOut <= accDataIn;
      if (accValidIn && fifoEmpty) errOut <= 1'b1;
    end
  end

  assign busyOut = (state == STREAM) || (occupancy != '0);

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (MAX_OUTSTANDING)
  ) tagFifo (
    .clkIn    (clkIn),
    .rstIn    (rstIn),
    .pushIn   (pushTag),
    .dataIn   (winner),
    .popIn    (popTag),
    .dataOut  (headTag),
    .fullOut  (fifoFull),
    .emptyOut (fifoEmpty),
    .countOut (occupancy)
  );

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter: per-requester beat queues drive the streams,
// the bench stands in for the accumulator and checks grant order and result routing.
module tb_accum_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              clkIn = 1'b0;
  logic              rstIn;
  logic [NREQ*DW-1:0] reqDataIn;
  logic [NREQ-1:0]   reqValidIn, reqLastIn, reqReadyOut;
  logic [DW-1:0]     accDataOut, accDataIn, resDataOut;
  logic              accValidOut, accLastOut, accValidIn;
  logic [NREQ-1:0]   resValidOut;
  logic              busyOut, errOut;

  int checkCount = 0;
  int failCount  = 0;

  logic [32:0] beatQ [NREQ][$];
  int unsigned grantLog [$];

  accum_arbiter #(
    .FRAC_WIDTH      (24),
    .EXP_WIDTH       (8),
    .NUM_REQ         (NREQ),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .reqDataIn   (reqDataIn),
    .reqValidIn  (reqValidIn),
    .reqLastIn   (reqLastIn),
    .reqReadyOut (reqReadyOut),
    .accDataOut  (accDataOut),
    .accValidOut (accValidOut),
    .accLastOut  (accLastOut),
    .accDataIn   (accDataIn),
    .accValidIn  (accValidIn),
    .resDataOut  (resDataOut),
    .resValidOut (resValidOut),
    .busyOut     (busyOut),
    .errOut      (errOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic driveReqs();
    for (int r = 0; r < NREQ; r++) begin
      if (beatQ[r].size() > 0) begin
        reqValidIn[r]            = 1'b1;
        reqLastIn[r]             = beatQ[r][0][32];
        reqDataIn[r*DW +: DW]    = beatQ[r][0][31:0];
      end else begin
        reqValidIn[r] = 1'b0;
        reqLastIn[r]  = 1'b0;
      end
    end
  endtask

  task automatic addPacket(input int r, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) beatQ[r].push_back({(k == n - 1), base + 32'(k)});
  endtask

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < NREQ; r++) s += beatQ[r].size();
    return s;
  endfunction

  // One clock: retire accepted beats, then check the registered accumulator feed.
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic [32:0]     beat;
    logic            hadBeat;
    acc     = reqValidIn & reqReadyOut;
    hadBeat = 1'b0;
    beat    = '0;
    check("readyOneHot", 32'($countones(reqReadyOut) <= 1), 32'd1);
    for (int r = 0; r < NREQ; r++) begin
      if (acc[r] && beatQ[r].size() > 0) begin
        beat    = beatQ[r].pop_front();
        hadBeat = 1'b1;
        if (beat[32]) grantLog.push_back(r);
      end
    end
    @(posedge clkIn);
    #1;
    check("accValid", 32'(accValidOut), 32'(hadBeat));
    if (hadBeat) begin
      check("accData", accDataOut, beat[31:0]);
      check("accLast", 32'(accLastOut), 32'(beat[32]));
    end
    driveReqs();
  endtask

  task automatic checkQuiet();
    check("rstReady", 32'(reqReadyOut), 32'd0);
    check("rstAccValid", 32'(accValidOut), 32'd0);
    check("rstAccLast", 32'(accLastOut), 32'd0);
    check("rstAccData", accDataOut, 32'd0);
    check("rstResValid", 32'(resValidOut), 32'd0);
    check("rstResData", resDataOut, 32'd0);
    check("rstBusy", 32'(busyOut), 32'd0);
    check("rstErr", 32'(errOut), 32'd0);
  endtask

  task automatic checkGrants(input int n, input logic [31:0] seq);
    check("grantCount", 32'(grantLog.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (grantLog.size() > 0) check("grantOrder", grantLog.pop_front(), 32'(seq[4*(n-1-i) +: 4]));
    grantLog.delete();
  endtask

  task automatic expectResult(input logic [31:0] data, input logic [3:0] owner);
    accDataIn  = data;
    accValidIn = 1'b1;
    tick();
    accValidIn = 1'b0;
    check("resValid", 32'(resValidOut), 32'(owner));
    check("resData", resDataOut, data);
  endtask

  task automatic doReset();
    rstIn = 1'b1;
    for (int r = 0; r < NREQ; r++) beatQ[r].delete();
    grantLog.delete();
    accValidIn = 1'b0;
    driveReqs();
    tick();
    rstIn = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    logic [3:0] owners;
    rstIn = 1'b1; reqDataIn = '0; reqValidIn = '0; reqLastIn = '0;
    accDataIn = '0; accValidIn = 1'b0;
    tick(); tick();
    checkQuiet();
    rstIn = 1'b0;
    tick();
    checkQuiet();

    // Single requester: 1.0 + 2.0 + 3.0
    beatQ[0].push_back({1'b0, 32'h3F800000});
    beatQ[0].push_back({1'b0, 32'h40000000});
    beatQ[0].push_back({1'b1, 32'h40400000});
    driveReqs();
    check("idleReady", 32'(reqReadyOut), 32'd0);
    tick();
    check("grantReady", 32'(reqReadyOut), 32'b0001);
    check("streamBusy", 32'(busyOut), 32'd1);
    tick(); tick(); tick();
    check("afterLastReady", 32'(reqReadyOut), 32'd0);
    check("outstandingBusy", 32'(busyOut), 32'd1);
    tick();
    expectResult(32'h40C00000, 4'b0001);
    check("drainedBusy", 32'(busyOut), 32'd0);
    tick();
    check("resStrobeDrop", 32'(resValidOut), 32'd0);
    check("resDataHold", resDataOut, 32'h40C00000);
    checkGrants(1, 32'h0);

    // Round robin from rrPtr=0 with 2-beat packets
    doReset();
    for (int r = 0; r < NREQ; r++) addPacket(r, 2, 32'h1000 * (r + 1));
    driveReqs();
    n = 0;
    while (pending() > 0 && n < 40) begin tick(); n++; end
    check("rrCycles", 32'(n), 32'd12);
    checkGrants(4, 32'h0123);
    for (int k = 0; k < NREQ; k++) begin
      owners = 4'b0001 << k;
      expectResult(32'hA000 + 32'(k), owners);
    end
    tick();
    check("rrDrained", 32'(busyOut), 32'd0);

    // Fairness after wrap, with a push and pop in the same cycle
    addPacket(1, 1, 32'h2100);
    addPacket(3, 1, 32'h2300);
    driveReqs();
    tick();
    check("fairFirst", 32'(reqReadyOut), 32'b0010);
    tick();
    accDataIn = 32'h11111111; accValidIn = 1'b1;
    tick();
    accValidIn = 1'b0;
    check("pushPopRes", 32'(resValidOut), 32'b0010);
    check("fairSecond", 32'(reqReadyOut), 32'b1000);
    tick();
    checkGrants(2, 32'h13);
    expectResult(32'h33333333, 4'b1000);
    tick();
    check("pushPopOcc", 32'(busyOut), 32'd0);

    // FIFO full: nine single-beat packets with no results returning
    for (int k = 0; k < 9; k++) addPacket(k % NREQ, 1, 32'h3000 + 32'(k));
    driveReqs();
    n = 0;
    while (grantLog.size() < 8 && n < 40) begin tick(); n++; end
    check("fillCycles", 32'(n), 32'd16);
    checkGrants(8, 32'h01230123);
    tick(); tick(); tick();
    check("fullStall", 32'(reqReadyOut), 32'd0);
    check("fullPending", 32'(beatQ[0].size()), 32'd1);
    expectResult(32'h4000, 4'b0001);
    check("fullPopNoGrant", 32'(reqReadyOut), 32'd0);
    tick();
    check("ninthGrant", 32'(reqReadyOut), 32'b0001);
    tick();
    checkGrants(1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      owners = 4'b0001 << ((k + 1) % NREQ);
      expectResult(32'h5000 + 32'(k), owners);
    end
    tick();
    check("fullDrained", 32'(busyOut), 32'd0);

    // Result with empty FIFO
    accDataIn = 32'hDEADBEEF; accValidIn = 1'b1;
    tick();
    accValidIn = 1'b0;
    check("errSet", 32'(errOut), 32'd1);
    check("errNoStrobe", 32'(resValidOut), 32'd0);
    tick();
    check("errSticky", 32'(errOut), 32'd1);
    check("errResHold", resDataOut, 32'h5007);

    // Asynchronous reset in the middle of a packet
    addPacket(2, 3, 32'h6000);
    driveReqs();
    tick();
    check("preRstGrant", 32'(reqReadyOut), 32'b0100);
    tick();
    #2;
    rstIn = 1'b1;
    #1;
    checkQuiet();
    for (int r = 0; r < NREQ; r++) beatQ[r].delete();
    grantLog.delete();
    driveReqs();
    tick();
    rstIn = 1'b0;
    addPacket(0, 1, 32'h7000);
    addPacket(3, 1, 32'h7300);
    driveReqs();
    n = 0;
    while (pending() > 0 && n < 20) begin tick(); n++; end
    check("postRstCycles", 32'(n), 32'd4);
    checkGrants(2, 32'h03);
    expectResult(32'h8000, 4'b0001);
    expectResult(32'h8300, 4'b1000);
    tick();
    check("postRstDrained", 32'(busyOut), 32'd0);
    check("postRstErr", 32'(errOut), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
- Shares one floating-point accumulator between NUM_REQ requesters, each supplying vector packets as valid/ready/last beat streams.
- Grants whole packets in round-robin order and drives the accumulator's data/valid/last inputs.
- Keeps an in-order tag FIFO of requester IDs and routes each accumulated sum back to the requester that owns it.
- Sits between the compute-unit request ports and the accumulator, in the dot-product/reduction path.

Parameters:
- FRAC_WIDTH, 24, fraction width of the floating-point type.
- EXP_WIDTH, 8, exponent width; DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH (derived).
- NUM_REQ, 4, number of requesters; REQ_W = max(1, clog2(NUM_REQ)) (derived).
- MAX_OUTSTANDING, 8, tag FIFO depth; must be ≤ 16, the accumulator's in-flight sum-ID space.

Ports:
- clkIn  in  1  clock
- rstIn  in  1  reset, asynchronous, active-high
- reqDataIn  in  NUM_REQ*DATA_WIDTH  packed beat data; requester r occupies slice r
- reqValidIn  in  NUM_REQ  beat valid per requester
- reqLastIn  in  NUM_REQ  last beat of packet per requester
- reqReadyOut  out  NUM_REQ  beat accepted when valid&ready
- accDataOut  out  DATA_WIDTH  to accumulator dataIn
- accValidOut  out  1  to accumulator validIn
- accLastOut  out  1  to accumulator lastIn
- accDataIn  in  DATA_WIDTH  from accumulator dataOut
- accValidIn  in  1  from accumulator validOut (final sums only)
- resDataOut  out  DATA_WIDTH  result data, shared by all requesters
- resValidOut  out  NUM_REQ  one-hot result strobe to the owning requester
- busyOut  out  1  packet streaming or sums outstanding
- errOut  out  1  sticky flag: a result arrived with the tag FIFO empty

Behaviour:
- Reset, asynchronous: state=IDLE, rrPtr=0, grant=0, FIFO empty, outstanding=0.
  - All outputs 0: reqReadyOut, accValidOut, accLastOut, accDataOut, resValidOut, resDataOut, busyOut, errOut.
  - The accumulator shares rstIn, so in-flight sums are discarded. A packet interrupted by reset is lost and not resumed.
- FSM has two states.
- IDLE:
  - reqReadyOut=0.
  - If any reqValidIn bit is set and FIFO not full: pick the first valid requester searching from rrPtr upward, wrapping at NUM_REQ.
  - Then: grant<=winner, push winner ID to the tag FIFO, state<=STREAM.
  - If FIFO full: stay in IDLE with no grant, even if requests are pending.
- STREAM:
  - reqReadyOut = one-hot(grant); all other bits are 0.
  - On an accepted beat: accDataOut<=slice, accValidOut<=1, accLastOut<=reqLastIn[grant]. This is a registered 1-cycle path; otherwise accValidOut<=0 and accLastOut<=0.
  - On an accepted beat with last=1: rrPtr<=grant+1 (mod NUM_REQ), state<=IDLE.
  - Idle cycles inside a packet (valid low) are legal. Grant is held until the last beat.
- Requester streams:
  - Zero-length packets are unsupported; every packet has at least 1 beat.
  - Data and last must stay stable while valid && !ready.
- Arbitration gap: one bubble cycle (IDLE) between packets. Minimum packet cost is 2 cycles.
- Result path:
  - On accValidIn: pop FIFO head h, resDataOut<=accDataIn, resValidOut<=one-hot(h). Registered, 1 cycle.
  - Otherwise resValidOut=0 and resDataOut holds its value.
  - Results return in packet-grant order, which the accumulator guarantees.
- Boundary cases:
  - Simultaneous push (grant) and pop (result) in one cycle: occupancy unchanged, both operations honoured.
  - accValidIn with FIFO empty: errOut<=1 (sticky until reset), resValidOut stays 0, no pointer change.
- Outstanding count = FIFO occupancy; at most MAX_OUTSTANDING.
- busyOut = (state==STREAM) || FIFO non-empty.

Decomposition:
- Shared package holds:
  - FRAC_WIDTH/EXP_WIDTH defaults.
  - The accumulator's ADD_LATENCY and its 16-entry in-flight ID limit.
  - FSM state encodings IDLE=0, STREAM=1.
- One natural sub-module: sync_fifo (width REQ_W, depth MAX_OUTSTANDING, full/empty/count outputs) for the tag queue.

Test Plan:
- Single requester:
  - Stimulus: req0 sends 3 beats 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0), last on beat 3.
  - Response: accValidOut 3 cycles with accLastOut on the 3rd; when the accumulator returns, resDataOut=0x40C00000 (6.0) and resValidOut=4'b0001.
- Round robin:
  - Stimulus: all 4 requesters valid from cycle 0 with 2-beat packets, rrPtr=0.
  - Response: grant order 0,1,2,3; each packet takes 3 cycles (bubble + 2 beats); results strobe 0001, 0010, 0100, 1000 in order.
- Fairness after wrap:
  - Stimulus: req3 finishes (rrPtr=0), then req1 and req3 both valid.
  - Response: req1 granted first, then req3.
- FIFO full:
  - Stimulus: hold accValidIn=0 and issue 9 single-beat packets.
  - Response: 8 grants, the 9th held in IDLE with reqReadyOut=0; one accValidIn pulse lets the 9th grant occur on the next cycle.
- Error and reset:
  - Stimulus: pulse accValidIn with FIFO empty.
  - Response: errOut=1 and stays 1 with resValidOut=0.
  - Stimulus: assert rstIn mid-STREAM.
  - Response: all outputs 0 immediately (asynchronous), errOut=0, and the next grant goes to the lowest valid requester from rrPtr=0.
